// File: rtl/dfr_mem_arbiter.sv
// Three-requester arbiter for a single-port RAM with round-robin
// grants, owner locking and per-requester starvation flags.
module dfr_mem_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 64
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic [2:0]              req,
    input  logic [2:0]              lock,
    input  logic [2:0]              wen,
    input  logic [3*ADDR_WIDTH-1:0] addr,
    input  logic [3*DATA_WIDTH-1:0] wdata,
    output logic [2:0]              gnt,
    output logic [2:0]              rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    ram_wen,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_din,
    input  logic [DATA_WIDTH-1:0]   ram_dout,
    input  logic                    err_clr,
    output logic [2:0]              starve_err
);

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        LOCKED
    } state_t;

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] owner;
    logic [1:0] win;
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [2:0] gnt_c;
    logic [2:0] starve_set;
    logic [7:0] wait_cnt [3];

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    always_comb begin
        gnt_c = 3'b000;
        win   = ptr;
        c0    = inc3(ptr);
        c1    = inc3(c0);
        c2    = inc3(c1);
        if (state == LOCKED) begin
            if (req[owner] && lock[owner]) begin
                win        = owner;
                gnt_c[win] = 1'b1;
            end
        end else begin
            if (req[c0]) begin
                win = c0;
            end else if (req[c1]) begin
                win = c1;
            end else begin
                win = c2;
            end
            gnt_c[win] = |req;
        end
    end

    // Reset gates the combinational grant so outputs drop at once.
    assign gnt   = gnt_c & {3{S_AXI_ARESETN}};
    assign rdata = ram_dout;

    always_comb begin
        ram_wen  = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        for (int i = 0; i < 3; i++) begin
            if (gnt[i]) begin
                ram_wen  = wen[i];
                ram_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                ram_din  = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        starve_set = 3'b000;
        for (int i = 0; i < 3; i++) begin
            starve_set[i] = req[i] && !gnt_c[i] &&
                            (wait_cnt[i] == MAX_W - 8'd1);
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state  <= IDLE;
            ptr    <= 2'd2;
            owner  <= 2'd0;
            rvalid <= 3'b000;
        end else begin
            rvalid <= gnt_c & ~wen;
            if (|gnt_c) begin
                ptr   <= win;
                owner <= win;
                if (state == LOCKED || lock[win]) begin
                    state <= LOCKED;
                end else begin
                    state <= ARB;
                end
            end else begin
                state <= (|req) ? ARB : IDLE;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < 3; i++) begin
                wait_cnt[i] <= 8'd0;
            end
            starve_err <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (req[i] && !gnt_c[i]) begin
                    if (wait_cnt[i] != 8'hff) begin
                        wait_cnt[i] <= wait_cnt[i] + 8'd1;
                    end
                end else begin
                    wait_cnt[i] <= 8'd0;
                end
            end
            starve_err <= (starve_err & ~{3{err_clr}}) | starve_set;
        end
    end

endmodule
